// File: rtl/cmerge6_arb.sv
// cmerge6_arb: six-input round-robin arbitrating merge stage.
//
// Collects drive/free pulse transactions from up to six upstream channels and
// forwards them one at a time onto a single downstream channel. The winning
// channel's payload is registered and held on o_data until the next fire.
//
// The asynchronous click behaviour is realised on a free-running delay-unit
// timebase i_clk: one delay unit equals one i_clk period. Every incoming
// request/acknowledge pulse passes through a two-flop capture stage. That
// stage plays the role of the mutex cells: requests seen by the arbiter are
// metastability-free, and the grant is always one-hot.
//
// Optional build macro: CMERGE6_SRC_TAG_EN
//   defined   -> o_data is DATA_WIDTH+6 bits; the upper 6 bits are the
//                one-hot source tag (channel k -> bit k).
//   undefined -> o_data is DATA_WIDTH bits; no source tag register.
module cmerge6_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DELAY_NUMS = 1
) (
    input  logic                  i_clk,
    input  logic                  rstn,
    input  logic                  i_drive0,
    input  logic                  i_drive1,
    input  logic                  i_drive2,
    input  logic                  i_drive3,
    input  logic                  i_drive4,
    input  logic                  i_drive5,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_data3,
    input  logic [DATA_WIDTH-1:0] i_data4,
    input  logic [DATA_WIDTH-1:0] i_data5,
    output logic                  o_free0,
    output logic                  o_free1,
    output logic                  o_free2,
    output logic                  o_free3,
    output logic                  o_free4,
    output logic                  o_free5,
    output logic                  o_driveNext,
    input  logic                  i_freeNext,
`ifdef CMERGE6_SRC_TAG_EN
    output logic [DATA_WIDTH+5:0] o_data
`else
    output logic [DATA_WIDTH-1:0] o_data
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Index of the first set request at or after start, wrapping 5 -> 0.
    function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] start);
        logic [2:0] pick;
        logic [3:0] cand;
        pick = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            cand = {1'b0, start} + 4'(i);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end else begin
                cand = cand;
            end
            if (req[cand[2:0]]) begin
                pick = cand[2:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [5:0]            drv_raw_s;
    logic [DATA_WIDTH-1:0] data_arr_s [8];
    logic [5:0]            drv_meta_q, drv_sync_q, drv_prev_q;
    logic                  fn_meta_q, fn_sync_q, fn_prev_q;
    logic [5:0]            drv_ev_s;
    logic                  fn_ev_s;
    logic [1:0]            state_q, state_d;
    logic [5:0]            pend_q, pend_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [5:0]            free_q;
    logic [DELAY_NUMS-1:0] drv_dly_q;
    logic                  fire_s;
    logic [2:0]            gnt_idx_s;
    logic [5:0]            grant_s;
`ifdef CMERGE6_SRC_TAG_EN
    logic [5:0]            src_q, src_d;
`endif

    assign drv_raw_s = {i_drive5, i_drive4, i_drive3, i_drive2, i_drive1, i_drive0};
    assign data_arr_s[0] = i_data0;
    assign data_arr_s[1] = i_data1;
    assign data_arr_s[2] = i_data2;
    assign data_arr_s[3] = i_data3;
    assign data_arr_s[4] = i_data4;
    assign data_arr_s[5] = i_data5;
    assign data_arr_s[6] = '0;
    assign data_arr_s[7] = '0;

    // Rising-edge events on the synchronised request and acknowledge lines.
    assign drv_ev_s  = drv_sync_q & ~drv_prev_q;
    assign fn_ev_s   = fn_sync_q & ~fn_prev_q;

    assign fire_s    = (state_q == ST_ARB) && (pend_q != 6'd0);
    assign gnt_idx_s = rr_pick(pend_q, ptr_q);
    assign grant_s   = fire_s ? (6'd1 << gnt_idx_s) : 6'd0;

    // Capture stage: two flops per line plus a previous-value flop for edge detection.
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            drv_meta_q <= 6'd0;
            drv_sync_q <= 6'd0;
            drv_prev_q <= 6'd0;
            fn_meta_q  <= 1'b0;
            fn_sync_q  <= 1'b0;
            fn_prev_q  <= 1'b0;
        end else begin
            drv_meta_q <= drv_raw_s;
            drv_sync_q <= drv_meta_q;
            drv_prev_q <= drv_sync_q;
            fn_meta_q  <= i_freeNext;
            fn_sync_q  <= fn_meta_q;
            fn_prev_q  <= fn_sync_q;
        end
    end

    // Next-state logic: pending flags, IDLE/ARB/WAIT sequencing, fire-time payload and pointer.
    always_comb begin
        pend_d  = (pend_q & ~grant_s) | drv_ev_s;
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
`ifdef CMERGE6_SRC_TAG_EN
        src_d   = src_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (drv_ev_s != 6'd0) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (fire_s) begin
                    state_d = ST_WAIT;
                end else if (pend_d != 6'd0) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An acknowledge outside WAIT never reaches this branch, so it is ignored.
                if (fn_ev_s) begin
                    state_d = (pend_d != 6'd0) ? ST_ARB : ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fire_s) begin
            data_d = data_arr_s[gnt_idx_s];
            ptr_d  = (gnt_idx_s == 3'd5) ? 3'd0 : gnt_idx_s + 3'd1;
`ifdef CMERGE6_SRC_TAG_EN
            src_d  = grant_s;
`endif
        end else begin
            data_d = data_q;
            ptr_d  = ptr_q;
        end
    end

    // State registers; the free pulse lags fire by one unit, the downstream drive by DELAY_NUMS units.
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            pend_q    <= 6'd0;
            ptr_q     <= 3'd0;
            data_q    <= '0;
            free_q    <= 6'd0;
            drv_dly_q <= '0;
`ifdef CMERGE6_SRC_TAG_EN
            src_q     <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            free_q    <= grant_s;
            drv_dly_q[0] <= fire_s;
            for (int i = 1; i < DELAY_NUMS; i++) begin
                drv_dly_q[i] <= drv_dly_q[i-1];
            end
`ifdef CMERGE6_SRC_TAG_EN
            src_q     <= src_d;
`endif
        end
    end

    assign o_free0     = free_q[0];
    assign o_free1     = free_q[1];
    assign o_free2     = free_q[2];
    assign o_free3     = free_q[3];
    assign o_free4     = free_q[4];
    assign o_free5     = free_q[5];
    assign o_driveNext = drv_dly_q[DELAY_NUMS-1];
`ifdef CMERGE6_SRC_TAG_EN
    assign o_data      = {src_q, data_q};
`else
    assign o_data      = data_q;
`endif

endmodule

// File: tb/tb_cmerge6_arb.sv
// Directed scoreboard bench for cmerge6_arb.
module tb_cmerge6_arb;
    localparam int DW = 32;
    localparam int DN = 1;
`ifdef CMERGE6_SRC_TAG_EN
    localparam int OW = DW + 6;
`else
    localparam int OW = DW;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [5:0]    drv;
    logic [DW-1:0] dat [6];
    logic [5:0]    fre;
    logic          drv_next;
    logic          free_next;
    logic [OW-1:0] o_data;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   drv_cnt = 0;
    int   free_cnt = 0;
    int   free_ch_cnt [6] = '{0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    cmerge6_arb #(.DATA_WIDTH(DW), .DELAY_NUMS(DN)) dut (
        .i_clk(clk), .rstn(rstn),
        .i_drive0(drv[0]), .i_drive1(drv[1]), .i_drive2(drv[2]),
        .i_drive3(drv[3]), .i_drive4(drv[4]), .i_drive5(drv[5]),
        .i_data0(dat[0]), .i_data1(dat[1]), .i_data2(dat[2]),
        .i_data3(dat[3]), .i_data4(dat[4]), .i_data5(dat[5]),
        .o_free0(fre[0]), .o_free1(fre[1]), .o_free2(fre[2]),
        .o_free3(fre[3]), .o_free4(fre[4]), .o_free5(fre[5]),
        .o_driveNext(drv_next), .i_freeNext(free_next), .o_data(o_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input exp_t e);
        logic [5:0] tag;
        tag = 6'd1 << e.ch;
`ifdef CMERGE6_SRC_TAG_EN
        return {26'd0, tag, e.data};
`else
        return {32'd0, e.data};
`endif
    endfunction

    // Output monitor: samples 2 ns after each rising edge, checks pulses against the scoreboard.
    always begin
        @(posedge clk);
        #2;
        if (fre != 6'd0) begin
            free_cnt++;
            for (int k = 0; k < 6; k++) begin
                if (fre[k]) free_ch_cnt[k]++;
            end
            chk("free_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("free_onehot", {58'd0, fre}, {58'd0, 6'(6'd1 << sb[0].ch)});
                chk("data_at_free", 64'(o_data), exp_word(sb[0]));
            end
        end
        if (drv_next) begin
            drv_cnt++;
            chk("drive_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("data_at_drive", 64'(o_data), exp_word(mon_e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_drv(input logic [5:0] m);
        @(negedge clk);
        drv = m;
        @(negedge clk);
        drv = 6'd0;
    endtask

    task automatic pulse_fn();
        @(negedge clk);
        free_next = 1'b1;
        @(negedge clk);
        free_next = 1'b0;
    endtask

    task automatic push(input int ch);
        sb.push_back('{ch: ch, data: dat[ch]});
    endtask

    task automatic wait_drv(input int target, input string tag);
        int n;
        n = 0;
        while (drv_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(drv_cnt), 64'(target));
    endtask

    initial begin
        rstn = 1'b0;
        drv = 6'd0;
        free_next = 1'b0;
        for (int k = 0; k < 6; k++) dat[k] = '0;
        tick(3);

        // Reset: no activity while rstn is low, none on release.
        chk("reset_o_data", 64'(o_data), 64'd0);
        chk("reset_free", {58'd0, fre}, 64'd0);
        chk("reset_drive", 64'(drv_next), 64'd0);
        pulse_drv(6'h3F);
        tick(5);
        chk("reset_no_drive", 64'(drv_cnt), 64'd0);
        chk("reset_no_free", 64'(free_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(20);
        chk("release_no_drive", 64'(drv_cnt), 64'd0);
        chk("release_no_free", 64'(free_cnt), 64'd0);

        // Single request on channel 3.
        dat[3] = 32'hA5A5_0003;
        push(3);
        pulse_drv(6'b001000);
        wait_drv(1, "single_ch3");
        chk("single_free3", 64'(free_ch_cnt[3]), 64'd1);
        tick(5);
        chk("single_busy_hold", 64'(drv_cnt), 64'd1);
        pulse_fn();
        tick(10);
        chk("single_idle", 64'(drv_cnt), 64'd1);

        // Channel 5 alone wraps the pointer back to 0.
        dat[5] = 32'h5555_0005;
        push(5);
        pulse_drv(6'b100000);
        wait_drv(2, "wrap_ch5");
        pulse_fn();

        // Simultaneous 1 and 4 from pointer 0: 1 first.
        dat[1] = 32'h1111_0001;
        dat[4] = 32'h4444_0004;
        push(1);
        push(4);
        pulse_drv(6'b010010);
        wait_drv(3, "simul_first");
        chk("simul_free1", 64'(free_ch_cnt[1]), 64'd1);
        tick(8);
        chk("simul_one_at_a_time", 64'(drv_cnt), 64'd3);
        pulse_fn();
        wait_drv(4, "simul_second");
        chk("simul_free4", 64'(free_ch_cnt[4]), 64'd1);
        pulse_fn();

        // Pointer 5 -> serving channel 1 alone leaves pointer at 2.
        push(1);
        pulse_drv(6'b000010);
        wait_drv(5, "ptr_to_2");
        pulse_fn();

        // All six pending with pointer 2: order 2,3,4,5,0,1.
        for (int k = 0; k < 6; k++) dat[k] = 32'hC0DE_0000 | 32'(k);
        push(2); push(3); push(4); push(5); push(0); push(1);
        pulse_drv(6'h3F);
        for (int j = 0; j < 6; j++) begin
            wait_drv(6 + j, "six_serve");
            tick(6);
            chk("six_no_early", 64'(drv_cnt), 64'(6 + j));
            pulse_fn();
        end

        // Request (duplicated) during WAIT is held until the downstream ack.
        dat[2] = 32'h2222_0002;
        dat[0] = 32'h0000_AAAA;
        push(2);
        pulse_drv(6'b000100);
        wait_drv(12, "wait_ch2");
        push(0);
        pulse_drv(6'b000001);
        tick(2);
        pulse_drv(6'b000001);
        tick(10);
        chk("no_free0_in_wait", 64'(free_ch_cnt[0]), 64'd1);
        pulse_fn();
        wait_drv(13, "served_ch0");
        chk("free0_after_ack", 64'(free_ch_cnt[0]), 64'd2);
        pulse_fn();
        tick(20);
        chk("dup_ignored", 64'(drv_cnt), 64'd13);

        // Reset mid-WAIT drops the pending request and restores pointer 0.
        dat[3] = 32'h3333_0033;
        push(3);
        pulse_drv(6'b001000);
        wait_drv(14, "pre_reset_ch3");
        pulse_drv(6'b010000);
        tick(3);
        @(negedge clk);
        rstn = 1'b0;
        tick(2);
        chk("midreset_o_data", 64'(o_data), 64'd0);
        chk("midreset_free", {58'd0, fre}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(5);
        pulse_fn();
        tick(20);
        chk("reset_drops_pending", 64'(drv_cnt), 64'd14);
        dat[1] = 32'h1010_1010;
        dat[5] = 32'h5050_5050;
        push(1);
        push(5);
        pulse_drv(6'b100010);
        wait_drv(15, "ptr0_after_reset");
        pulse_fn();
        wait_drv(16, "after_reset_second");
        pulse_fn();
        tick(10);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("final_drive_count", 64'(drv_cnt), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmerge6_arb.md
# cmerge6_arb

Six-input asynchronous arbitrating merge stage for the click-based pipeline. It collects drive/free pulse transactions from up to six upstream channels and forwards them one at a time onto a single downstream channel, registering the winning channel's data. It is the converging counterpart of the six-way selector: its output can feed a selector's tagged-data input directly, closing fork/join loops in the dataflow fabric.

## Interface
- DATA_WIDTH, 32: payload width per channel.
- DELAY_NUMS, 1: delay units between the internal fire event and o_driveNext (data setup margin).
- rstn  input  1  asynchronous reset, active-low; clears all state immediately.
- i_drive0..i_drive5  input  1 each  request pulse from upstream channel k.
- i_data0..i_data5  input  DATA_WIDTH each  payload of channel k; stable from i_drivek until o_freek.
- o_free0..o_free5  output  1 each  acknowledge pulse to channel k after its data is captured.
- o_driveNext  output  1  request pulse to downstream.
- i_freeNext  input  1  acknowledge pulse from downstream.
- o_data  output  DATA_WIDTH (+6 with CMERGE6_SRC_TAG_EN)  registered payload.

## Operation
- No clock; all state advances on signal edges. "Event" means a rising edge.
- Pending flags p[5:0]: p[k] set on i_drivek event, cleared when channel k is granted and its o_freek issued.
- Busy flag: set on fire, cleared on i_freeNext event. Exactly one transaction outstanding downstream.
- Arbitration when not busy and any p[k] = 1: round-robin, search starting at ptr, wrapping 5 -> 0; first set flag wins. Request capture goes through dont_touch mutex cells so grant is one-hot and metastability-free.
- Fire on grant k: r_data <= i_datak; r_src <= one-hot(k); ptr <= (k+1) mod 6; busy <= 1.
- After fire: o_freek pulse (via delay1U-class element), o_driveNext pulse after DELAY_NUMS units.
- o_data = r_data (tag appended per Configuration); held until next fire.
- States: IDLE (busy 0, no pending) -> ARB (busy 0, pending) -> WAIT (busy 1) -> on i_freeNext: ARB if pending else IDLE.
- Boundaries:
  - Simultaneous requests: one granted per fire, others stay pending; no request lost.
  - Second i_drivek while p[k] = 1: protocol violation; ignored, single transaction counted.
  - Request arriving during WAIT: latched, served after i_freeNext.
  - i_freeNext while not busy: ignored.
  - All six pending: served in ptr order, each within six downstream handshakes (no starvation).
  - Reset mid-operation: p, busy, r_data, r_src cleared, ptr = 0; in-flight pulses dropped; no spurious o_free/o_driveNext on rstn release.

## Timing
- Reset values: o_free0..5 = 0, o_driveNext = 0, o_data = 0, ptr = 0.
- Latency i_drivek -> fire: arbitration + mutex delay, bounded, no data dependence.
- fire -> o_data valid: one flop clk-to-q.
- fire -> o_driveNext: DELAY_NUMS delay units; o_data stable before o_driveNext rises.
- fire -> o_freek: one delay unit; upstream may change i_datak only after o_freek.
- Throughput: one transaction per downstream round trip (o_driveNext -> i_freeNext -> next fire).
- Pulse widths match the pipeline library's sender/relay pulse width.

## Configuration
- CMERGE6_SRC_TAG_EN defined: o_data is DATA_WIDTH+6 bits, upper 6 bits = r_src one-hot source tag (selector-compatible format, channel k -> bit k).
- Undefined: o_data is DATA_WIDTH bits, no tag; r_src not implemented.

## Test plan
- Reset: hold rstn = 0, pulse all i_drive -> no outputs toggle; o_data = 0; release -> no pulses.
- Single request: i_drive3 with i_data3 = 0xA5A5_0003 -> o_data = 0xA5A5_0003 (tag 6'b001000), o_free3 and o_driveNext pulse once; answer i_freeNext -> back to IDLE.
- Simultaneous i_drive1, i_drive4 from ptr 0 -> ch1 served first, ch4 after first i_freeNext; ptr ends at 5.
- All six pending with ptr = 2 -> order 2,3,4,5,0,1; exactly six o_driveNext pulses, each after previous i_freeNext.
- Request during WAIT: i_drive0 while busy -> no o_free0 until i_freeNext, then served.
- Reset mid-WAIT: assert rstn after fire -> o_data = 0, ptr = 0, pending cleared; later i_freeNext ignored.
